// File: rtl/cardinal_dmem_arbiter.sv
// cardinal_dmem_arbiter: round-robin arbiter sharing one dmem port among N_REQ requesters.
// Optional DMEM_ARB_LOCK_EN adds a per-requester lock input for atomic read-modify-write.
module cardinal_dmem_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          lock,
`endif
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          wr_en,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      memEn,
  output logic                      memWrEn,
  output logic [ADDR_W-1:0]         memAddr,
  output logic [DATA_W-1:0]         memDataIn,
  input  logic [DATA_W-1:0]         memDataOut
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0]     r_ptr, r_rd_tag, w_win, w_cand;
  logic              r_rd_pend, w_any, w_rd_out;
  logic [DATA_W-1:0] r_rdata;
  logic [N_REQ-1:0]  w_elig;
`ifdef DMEM_ARB_LOCK_EN
  logic              r_lock_own;
  logic [PW-1:0]     r_lock_idx;
  assign w_elig = reset ? '0 : r_lock_own ? (req & (N_REQ'(1) << r_lock_idx)) : req;
`else
  assign w_elig = reset ? '0 : req;
`endif
  // descending scan so the candidate closest to r_ptr is the last one written
  always_comb begin
    w_win  = r_ptr;
    w_any  = 1'b0;
    w_cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = r_ptr + PW'(k);
      if (w_elig[w_cand]) begin
        w_win = w_cand;
        w_any = 1'b1;
      end
    end
  end
  assign gnt       = w_any ? (N_REQ'(1) << w_win) : '0;
  assign memEn     = w_any;
  assign memWrEn   = w_any & wr_en[w_win];
  assign memAddr   = w_any ? addr[w_win*ADDR_W +: ADDR_W] : '0;
  assign memDataIn = w_any ? wdata[w_win*DATA_W +: DATA_W] : '0;
  // a response landing while reset is high is dropped
  assign w_rd_out  = r_rd_pend & ~reset;
  assign rvalid    = w_rd_out ? (N_REQ'(1) << r_rd_tag) : '0;
  assign rdata     = w_rd_out ? memDataOut : r_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_tag  <= '0;
      r_rdata   <= '0;
    end else begin
      r_rd_pend <= w_any & ~wr_en[w_win];
      if (w_any) r_ptr <= w_win + PW'(1);
      if (w_any & ~wr_en[w_win]) r_rd_tag <= w_win;
      if (r_rd_pend) r_rdata <= memDataOut;
    end
  end
`ifdef DMEM_ARB_LOCK_EN
  // while locked the owner is the only winner, so r_ptr already sits at r_lock_idx+1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_own <= 1'b0;
      r_lock_idx <= '0;
    end else if (r_lock_own) begin
      if (!req[r_lock_idx] || (w_any && !lock[w_win])) r_lock_own <= 1'b0;
    end else if (w_any && lock[w_win]) begin
      r_lock_own <= 1'b1;
      r_lock_idx <= w_win;
    end
  end
`endif
endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
// tb_cardinal_dmem_arbiter: table-driven check of arbitration order, read return, write-first and reset drop.
module tb_cardinal_dmem_arbiter;
  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req, wr_en, lock, gnt, rvalid;
  logic [31:0]   addr;
  logic [255:0]  wdata;
  logic [63:0]   rdata, memDataIn, memDataOut;
  logic          memEn, memWrEn;
  logic [7:0]    memAddr;
  logic [63:0]   mem [256];
  int            n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  cardinal_dmem_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
`ifdef DMEM_ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .memEn(memEn), .memWrEn(memWrEn), .memAddr(memAddr),
    .memDataIn(memDataIn), .memDataOut(memDataOut)
  );

  // write-first single-port dmem with one-cycle read latency
  always @(posedge clk)
    if (memEn) begin
      if (memWrEn) mem[memAddr] <= memDataIn;
      else memDataOut <= mem[memAddr];
    end

  typedef struct {
    bit          rst;
    logic [3:0]  req, wr, lk;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [3:0]  gnt, rv;
    logic [63:0] rd;
    bit          ck;
  } vec_t;

  localparam logic [31:0] A = 32'h33323130;
  vec_t tv [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    reset = v.rst; req = v.req; wr_en = v.wr; lock = v.lk;
    addr = v.addr; wdata = {4{v.wd}};
    @(negedge clk);
    chk({tag, ".gnt"}, 64'(gnt), 64'(v.gnt));
    chk({tag, ".memEn"}, 64'(memEn), 64'(|v.gnt));
    chk({tag, ".rvalid"}, 64'(rvalid), 64'(v.rv));
    if (v.ck) chk({tag, ".rdata"}, rdata, v.rd);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[8'h10] = 64'hDEADBEEF00000001;
    for (int j = 0; j < 4; j++) mem[8'h30 + j] = 64'h1000 + 64'(j);
    memDataOut = '0;
    //            rst req     wr      lk  addr          wd    gnt     rv      rd                     ck
    tv[0]  = '{0, 4'b0001, 4'b0000, 4'b0, 32'h00000010, 64'h0, 4'b0001, 4'b0000, 64'h0,                0};
    tv[1]  = '{0, 4'b0000, 4'b0000, 4'b0, 32'h00000010, 64'h0, 4'b0000, 4'b0001, 64'hDEADBEEF00000001, 1};
    tv[2]  = '{1, 4'b1111, 4'b0000, 4'b0, A,            64'h0, 4'b0000, 4'b0000, 64'h0,                0};
    tv[3]  = '{0, 4'b1111, 4'b0000, 4'b0, A,            64'h0, 4'b0001, 4'b0000, 64'h0,                0};
    tv[4]  = '{0, 4'b1111, 4'b0000, 4'b0, A,            64'h0, 4'b0010, 4'b0001, 64'h1000,             1};
    tv[5]  = '{0, 4'b1111, 4'b0000, 4'b0, A,            64'h0, 4'b0100, 4'b0010, 64'h1001,             1};
    tv[6]  = '{0, 4'b1111, 4'b0000, 4'b0, A,            64'h0, 4'b1000, 4'b0100, 64'h1002,             1};
    tv[7]  = '{0, 4'b0010, 4'b0000, 4'b0, A,            64'h0, 4'b0010, 4'b1000, 64'h1003,             1};
    tv[8]  = '{0, 4'b1001, 4'b0000, 4'b0, A,            64'h0, 4'b1000, 4'b0010, 64'h1001,             1};
    tv[9]  = '{0, 4'b0001, 4'b0000, 4'b0, A,            64'h0, 4'b0001, 4'b1000, 64'h1003,             1};
    tv[10] = '{0, 4'b0100, 4'b0100, 4'b0, 32'h00200000, 64'h5, 4'b0100, 4'b0001, 64'h1000,             1};
    tv[11] = '{0, 4'b0001, 4'b0000, 4'b0, 32'h00000020, 64'h5, 4'b0001, 4'b0000, 64'h1000,             1};
    tv[12] = '{0, 4'b0000, 4'b0000, 4'b0, 32'h00000020, 64'h0, 4'b0000, 4'b0001, 64'h5,                1};
    tv[13] = '{0, 4'b0000, 4'b0000, 4'b0, 32'h00000020, 64'h0, 4'b0000, 4'b0000, 64'h5,                1};
    tv[14] = '{0, 4'b1101, 4'b0000, 4'b0, A,            64'h0, 4'b0100, 4'b0000, 64'h5,                1};
    tv[15] = '{0, 4'b1001, 4'b0000, 4'b0, A,            64'h0, 4'b1000, 4'b0100, 64'h1002,             1};
    tv[16] = '{0, 4'b0000, 4'b0000, 4'b0, A,            64'h0, 4'b0000, 4'b1000, 64'h1003,             1};
    reset = 1'b1; req = '0; wr_en = '0; lock = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset.rvalid", 64'(rvalid), 64'h0);
    chk("reset.memWrEn", 64'(memWrEn), 64'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) apply(tv[i], $sformatf("v%0d", i));
    // read in flight when reset hits: no response, pointer back to 0
    apply('{0, 4'b0010, 4'b0000, 4'b0, A, 64'h0, 4'b0010, 4'b0000, 64'h0,    0}, "rst_a");
    apply('{1, 4'b0000, 4'b0000, 4'b0, A, 64'h0, 4'b0000, 4'b0000, 64'h0,    0}, "rst_b");
    apply('{0, 4'b1111, 4'b0000, 4'b0, A, 64'h0, 4'b0001, 4'b0000, 64'h0,    0}, "rst_c");
    apply('{0, 4'b0100, 4'b0000, 4'b0, A, 64'h0, 4'b0100, 4'b0001, 64'h1000, 1}, "rst_d");
`ifdef DMEM_ARB_LOCK_EN
    apply('{1, 4'b1111, 4'b0000, 4'b0000, A, 64'h0, 4'b0000, 4'b0000, 64'h0, 0}, "lk_r");
    apply('{0, 4'b1111, 4'b0000, 4'b0000, A, 64'h0, 4'b0001, 4'b0000, 64'h0, 0}, "lk0");
    apply('{0, 4'b1111, 4'b0000, 4'b0010, A, 64'h0, 4'b0010, 4'b0001, 64'h0, 0}, "lk1");
    apply('{0, 4'b1111, 4'b0000, 4'b0010, A, 64'h0, 4'b0010, 4'b0010, 64'h0, 0}, "lk2");
    apply('{0, 4'b1111, 4'b0000, 4'b0010, A, 64'h0, 4'b0010, 4'b0010, 64'h0, 0}, "lk3");
    apply('{0, 4'b1111, 4'b0000, 4'b0000, A, 64'h0, 4'b0010, 4'b0010, 64'h0, 0}, "lk4");
    apply('{0, 4'b1111, 4'b0000, 4'b0000, A, 64'h0, 4'b0100, 4'b0010, 64'h0, 0}, "lk5");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
